rs_chien_err_pos_collector: RTL and testbench

Consumes per-cycle Chien search results (alpha indices plus per-lane "locator evaluated to zero" flags), converts hit roots to error positions and compacts them into an ordered list. Sits after the Chien root generator / locator evaluator in the RS decoder and feeds the Forney/correction stage through a valid/ready handshake. Flags decode failure when the root count disagrees with the locator degree or exceeds T_LEN.

---
 rtl/rs_chien_err_pos_collector.sv | 145 ++++++++++++++
 tb/tb_rs_chien_err_pos_collector.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_chien_err_pos_collector.sv
// Chien-search error position collector: turns per-lane root hits into a
// compacted, discovery-ordered error position list with a decode-fail verdict.
module rs_chien_err_pos_collector #(
  parameter int SYMB_WIDTH      = 8,
  parameter int ROOTS_PER_CYCLE = 4,
  parameter int CYCLES_NUM      = 64,
  parameter int T_LEN           = 8
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic                                  eval_vld,
  input  logic                                  start,
  input  logic [ROOTS_PER_CYCLE*SYMB_WIDTH-1:0] alpha_idx,
  input  logic [ROOTS_PER_CYCLE-1:0]            root_hit,
  input  logic [$clog2(T_LEN+1)-1:0]            err_deg,
  output logic                                  pos_vld,
  input  logic                                  pos_rdy,
  output logic [T_LEN*SYMB_WIDTH-1:0]           err_pos,
  output logic [$clog2(T_LEN+2)-1:0]            err_cnt,
  output logic                                  decode_fail,
  output logic                                  busy
);

  localparam int N      = 2**SYMB_WIDTH - 1;
  localparam int DEG_W  = $clog2(T_LEN+1);
  localparam int CNT_W  = $clog2(T_LEN+2);
  localparam int BEAT_W = (CYCLES_NUM > 1) ? $clog2(CYCLES_NUM) : 1;
  localparam logic [SYMB_WIDTH-1:0] N_SYM = SYMB_WIDTH'(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  // Index 0 maps to position 0; otherwise position is N - index.
  function automatic logic [SYMB_WIDTH-1:0] f_pos(input logic [SYMB_WIDTH-1:0] a);
    return (a == {SYMB_WIDTH{1'b0}}) ? {SYMB_WIDTH{1'b0}} : (N_SYM - a);
  endfunction

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [BEAT_W-1:0]            r_beat_cnt;
  logic [BEAT_W-1:0]            w_beat_base;
  logic [BEAT_W-1:0]            w_beat_nxt;
  logic [DEG_W-1:0]             r_deg;
  logic [DEG_W-1:0]             w_deg_nxt;
  logic [T_LEN*SYMB_WIDTH-1:0]  r_err_pos;
  logic [T_LEN*SYMB_WIDTH-1:0]  w_pos_nxt;
  logic [CNT_W-1:0]             r_err_cnt;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic                         r_ovf;
  logic                         w_ovf_nxt;
  logic                         r_decode_fail;
  logic                         w_fail_nxt;
  logic                         w_dfail_nxt;
  logic                         r_pos_vld;
  logic                         r_busy;
  logic                         w_accept;
  logic                         w_proc;
  logic                         w_last;

  // Beat acceptance, in-beat compaction and next-value computation.
  always_comb begin : p_datapath
    int                    v_cnt;
    logic                  v_q;
    logic [SYMB_WIDTH-1:0] v_a;
    w_accept    = eval_vld & start &
                  ((r_state == S_IDLE) | ((r_state == S_HOLD) & pos_rdy));
    w_proc      = w_accept | ((r_state == S_COLLECT) & eval_vld);
    w_beat_base = w_accept ? {BEAT_W{1'b0}} : r_beat_cnt;
    w_last      = w_proc & (w_beat_base == BEAT_W'(CYCLES_NUM - 1));
    w_deg_nxt   = w_accept ? err_deg : r_deg;
    w_pos_nxt   = w_accept ? {(T_LEN*SYMB_WIDTH){1'b0}} : r_err_pos;
    w_ovf_nxt   = w_accept ? 1'b0 : r_ovf;
    v_cnt       = w_accept ? 32'sd0 : int'(r_err_cnt);
    v_q         = 1'b0;
    v_a         = {SYMB_WIDTH{1'b0}};
    // Lanes are walked low to high so each lands at the running slot index.
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
      v_a = alpha_idx[i*SYMB_WIDTH +: SYMB_WIDTH];
      v_q = w_proc & root_hit[i] & (v_a < N_SYM);
      for (int k = 0; k < T_LEN; k++) begin
        w_pos_nxt[k*SYMB_WIDTH +: SYMB_WIDTH] = (v_q && (v_cnt == k)) ?
            f_pos(v_a) : w_pos_nxt[k*SYMB_WIDTH +: SYMB_WIDTH];
      end
      w_ovf_nxt = w_ovf_nxt | (v_q & (v_cnt >= T_LEN));
      v_cnt     = v_cnt + (v_q ? 32'sd1 : 32'sd0);
    end
    w_cnt_nxt   = (v_cnt > T_LEN + 1) ? CNT_W'(T_LEN + 1) : CNT_W'(v_cnt);
    w_fail_nxt  = w_ovf_nxt | (int'(w_cnt_nxt) != int'(w_deg_nxt));
    w_dfail_nxt = w_last ? w_fail_nxt : (w_accept ? 1'b0 : r_decode_fail);
    w_beat_nxt  = !w_proc ? r_beat_cnt :
                  (w_last ? {BEAT_W{1'b0}} : (w_beat_base + {{(BEAT_W-1){1'b0}}, 1'b1}));
  end

  // Frame state transitions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        w_state_nxt = w_proc ? (w_last ? S_HOLD : S_COLLECT) : r_state;
      end
      S_HOLD: begin
        w_state_nxt = w_proc ? (w_last ? S_HOLD : S_COLLECT) :
                      (pos_rdy ? S_IDLE : S_HOLD);
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and frame registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_beat_cnt    <= {BEAT_W{1'b0}};
      r_deg         <= {DEG_W{1'b0}};
      r_err_pos     <= {(T_LEN*SYMB_WIDTH){1'b0}};
      r_err_cnt     <= {CNT_W{1'b0}};
      r_ovf         <= 1'b0;
      r_decode_fail <= 1'b0;
      r_pos_vld     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_beat_cnt    <= w_beat_nxt;
      r_deg         <= w_deg_nxt;
      r_err_pos     <= w_pos_nxt;
      r_err_cnt     <= w_cnt_nxt;
      r_ovf         <= w_ovf_nxt;
      r_decode_fail <= w_dfail_nxt;
      r_pos_vld     <= (w_state_nxt == S_HOLD);
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign pos_vld     = r_pos_vld;
  assign busy        = r_busy;
  assign err_pos     = r_err_pos;
  assign err_cnt     = r_err_cnt;
  assign decode_fail = r_decode_fail;

endmodule

// File: tb/tb_rs_chien_err_pos_collector.sv
// Randomized bench for rs_chien_err_pos_collector against a queue-based
// reference model of the position list.
module tb_rs_chien_err_pos_collector;

  localparam int SW  = 8;
  localparam int RPC = 4;
  localparam int CN  = 64;
  localparam int TL  = 8;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             eval_vld;
  logic             start;
  logic [RPC*SW-1:0] alpha_idx;
  logic [RPC-1:0]   root_hit;
  logic [3:0]       err_deg;
  logic             pos_vld;
  logic             pos_rdy;
  logic [TL*SW-1:0] err_pos;
  logic [3:0]       err_cnt;
  logic             decode_fail;
  logic             busy;

  logic [3:0]       hit_tab [CN];
  logic [TL*SW-1:0] exp_pos;
  logic [3:0]       exp_cnt;
  logic             exp_fail;
  logic             early_vld;
  int               n_checks = 0;
  int               n_pass   = 0;

  rs_chien_err_pos_collector #(
    .SYMB_WIDTH(SW), .ROOTS_PER_CYCLE(RPC), .CYCLES_NUM(CN), .T_LEN(TL)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .eval_vld(eval_vld), .start(start),
    .alpha_idx(alpha_idx), .root_hit(root_hit), .err_deg(err_deg),
    .pos_vld(pos_vld), .pos_rdy(pos_rdy), .err_pos(err_pos),
    .err_cnt(err_cnt), .decode_fail(decode_fail), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    eval_vld  = 1'b0;
    start     = 1'b0;
    alpha_idx = '0;
    root_hit  = '0;
    err_deg   = 4'd0;
  endtask

  task automatic handshake();
    pos_rdy = 1'b1;
    tick();
    pos_rdy = 1'b0;
  endtask

  task automatic clear_hits();
    for (int b = 0; b < CN; b++) hit_tab[b] = 4'd0;
  endtask

  // Sets k distinct hits on real field elements (index 0..254).
  task automatic random_hits(input int k);
    int placed;
    int idx;
    placed = 0;
    while (placed < k) begin
      idx = $urandom_range(0, 254);
      if (hit_tab[idx/4][idx%4] == 1'b0) begin
        hit_tab[idx/4][idx%4] = 1'b1;
        placed++;
      end
    end
  endtask

  // Reference: walk the frame in index order, keep roots in a queue.
  function automatic void model(input int deg);
    int q[$];
    int n;
    int a;
    int sat;
    q = {};
    for (int b = 0; b < CN; b++)
      for (int l = 0; l < RPC; l++) begin
        a = 4 * b + l;
        if (hit_tab[b][l] && a < 255) q.push_back(a == 0 ? 0 : 255 - a);
      end
    n   = q.size();
    sat = (n > TL + 1) ? TL + 1 : n;
    exp_cnt = 4'(sat);
    exp_pos = '0;
    for (int k = 0; k < TL && k < n; k++) exp_pos[k*SW +: SW] = 8'(q[k]);
    exp_fail = (n > TL) || (sat != deg);
  endfunction

  task automatic drive_frame(input int deg, input int first_beat, input int last_beat,
                             input bit noisy);
    early_vld = 1'b0;
    for (int b = first_beat; b <= last_beat; b++) begin
      if (noisy && $urandom_range(0, 3) == 0) begin
        eval_vld  = 1'b0;
        start     = 1'($urandom_range(0, 1));
        alpha_idx = 32'($urandom);
        root_hit  = 4'($urandom);
        err_deg   = 4'($urandom);
        tick();
        if (pos_vld) early_vld = 1'b1;
      end
      eval_vld = 1'b1;
      start    = (b == 0) ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      for (int l = 0; l < RPC; l++) alpha_idx[l*SW +: SW] = 8'(4 * b + l);
      root_hit = hit_tab[b];
      err_deg  = (b == 0) ? 4'(deg) : 4'($urandom);
      tick();
      if (b != CN - 1 && pos_vld) early_vld = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    pos_rdy = 1'b0;
    idle_inputs();
    clear_hits();
    repeat (3) tick();
    n_checks++;
    if ({pos_vld, busy, decode_fail, err_cnt, err_pos} !== '0)
      $display("FAIL reset_held: vld=%0b busy=%0b fail=%0b cnt=%0d pos=%h, want all 0",
               pos_vld, busy, decode_fail, err_cnt, err_pos);
    else n_pass++;
    aresetn = 1'b1;
    tick();
    n_checks++;
    if ({pos_vld, busy, decode_fail, err_cnt, err_pos} !== '0)
      $display("FAIL reset_release: vld=%0b busy=%0b fail=%0b cnt=%0d pos=%h, want all 0",
               pos_vld, busy, decode_fail, err_cnt, err_pos);
    else n_pass++;
  endtask

  task automatic test_no_errors();
    clear_hits();
    model(0);
    drive_frame(0, 0, CN - 1, 1'b0);
    n_checks++;
    if (early_vld !== 1'b0 || pos_vld !== 1'b1 || busy !== 1'b1)
      $display("FAIL noerr_latency: early=%0b vld=%0b busy=%0b, want 0 1 1", early_vld, pos_vld, busy);
    else n_pass++;
    n_checks++;
    if ({err_cnt, decode_fail, err_pos} !== {4'd0, 1'b0, 64'd0})
      $display("FAIL noerr_result: cnt=%0d fail=%0b pos=%h, want 0 0 0", err_cnt, decode_fail, err_pos);
    else n_pass++;
    handshake();
    n_checks++;
    if (pos_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL noerr_release: vld=%0b busy=%0b, want 0 0", pos_vld, busy);
    else n_pass++;
  endtask

  task automatic test_two_errors();
    clear_hits();
    hit_tab[0]  = 4'b0010;
    hit_tab[10] = 4'b1000;
    model(2);
    drive_frame(2, 0, CN - 1, 1'b1);
    n_checks++;
    if (early_vld !== 1'b0 || pos_vld !== 1'b1)
      $display("FAIL two_latency: early=%0b vld=%0b, want 0 1", early_vld, pos_vld);
    else n_pass++;
    n_checks++;
    if ({err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos})
      $display("FAIL two_model: cnt=%0d fail=%0b pos=%h, want %0d %0b %h",
               err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
    else n_pass++;
    n_checks++;
    if (err_pos[15:0] !== {8'd212, 8'd254} || err_cnt !== 4'd2 || decode_fail !== 1'b0)
      $display("FAIL two_const: pos01=%h cnt=%0d fail=%0b, want d4fe 2 0",
               err_pos[15:0], err_cnt, decode_fail);
    else n_pass++;
    handshake();
  endtask

  task automatic test_same_beat();
    clear_hits();
    hit_tab[0]  = 4'b0101;
    hit_tab[63] = 4'b1000;
    model(2);
    drive_frame(2, 0, CN - 1, 1'b1);
    n_checks++;
    if ({err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos})
      $display("FAIL same_model: cnt=%0d fail=%0b pos=%h, want %0d %0b %h",
               err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
    else n_pass++;
    n_checks++;
    if (err_pos[15:0] !== {8'd253, 8'd0} || err_cnt !== 4'd2 || decode_fail !== 1'b0)
      $display("FAIL same_const: pos01=%h cnt=%0d fail=%0b, want fd00 2 0",
               err_pos[15:0], err_cnt, decode_fail);
    else n_pass++;
    handshake();
  endtask

  task automatic test_overflow();
    clear_hits();
    random_hits(9);
    model(8);
    drive_frame(8, 0, CN - 1, 1'b1);
    n_checks++;
    if ({err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos})
      $display("FAIL ovf_model: cnt=%0d fail=%0b pos=%h, want %0d %0b %h",
               err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
    else n_pass++;
    n_checks++;
    if (err_cnt !== 4'd9 || decode_fail !== 1'b1)
      $display("FAIL ovf_const: cnt=%0d fail=%0b, want 9 1", err_cnt, decode_fail);
    else n_pass++;
    handshake();
    clear_hits();
    random_hits(2);
    model(3);
    drive_frame(3, 0, CN - 1, 1'b0);
    n_checks++;
    if ({err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos} || decode_fail !== 1'b1)
      $display("FAIL degmis: cnt=%0d fail=%0b pos=%h, want %0d 1 %h",
               err_cnt, decode_fail, err_pos, exp_cnt, exp_pos);
    else n_pass++;
    handshake();
  endtask

  task automatic test_random();
    int k;
    int deg;
    for (int it = 0; it < 6; it++) begin
      clear_hits();
      k = $urandom_range(0, 11);
      random_hits(k);
      if ($urandom_range(0, 1) == 1) hit_tab[63][3] = 1'b1;
      deg = ($urandom_range(0, 1) == 1 && k <= TL) ? k : $urandom_range(0, 8);
      model(deg);
      drive_frame(deg, 0, CN - 1, 1'b1);
      n_checks++;
      if (early_vld !== 1'b0 || pos_vld !== 1'b1)
        $display("FAIL rand%0d_latency: early=%0b vld=%0b, want 0 1", it, early_vld, pos_vld);
      else n_pass++;
      n_checks++;
      if ({err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos})
        $display("FAIL rand%0d_model: cnt=%0d fail=%0b pos=%h, want %0d %0b %h",
                 it, err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
      else n_pass++;
      handshake();
      n_checks++;
      if (pos_vld !== 1'b0 || busy !== 1'b0)
        $display("FAIL rand%0d_release: vld=%0b busy=%0b, want 0 0", it, pos_vld, busy);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int deg_b;
    clear_hits();
    random_hits(3);
    model(3);
    drive_frame(3, 0, CN - 1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      eval_vld  = 1'b1;
      start     = 1'b0;
      alpha_idx = 32'($urandom);
      root_hit  = 4'($urandom);
      tick();
      n_checks++;
      if ({pos_vld, err_cnt, decode_fail, err_pos} !== {1'b1, exp_cnt, exp_fail, exp_pos})
        $display("FAIL stall%0d: vld=%0b cnt=%0d fail=%0b pos=%h, want 1 %0d %0b %h",
                 c, pos_vld, err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
      else n_pass++;
    end
    clear_hits();
    random_hits(4);
    hit_tab[0] = 4'b0110;
    deg_b = 6;
    model(deg_b);
    pos_rdy  = 1'b1;
    eval_vld = 1'b1;
    start    = 1'b1;
    for (int l = 0; l < RPC; l++) alpha_idx[l*SW +: SW] = 8'(l);
    root_hit = hit_tab[0];
    err_deg  = 4'(deg_b);
    tick();
    pos_rdy = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || pos_vld !== 1'b0)
      $display("FAIL b2b_accept: busy=%0b vld=%0b, want 1 0", busy, pos_vld);
    else n_pass++;
    drive_frame(deg_b, 1, CN - 1, 1'b0);
    n_checks++;
    if (early_vld !== 1'b0 || pos_vld !== 1'b1)
      $display("FAIL b2b_latency: early=%0b vld=%0b, want 0 1", early_vld, pos_vld);
    else n_pass++;
    n_checks++;
    if ({err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos})
      $display("FAIL b2b_model: cnt=%0d fail=%0b pos=%h, want %0d %0b %h",
               err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset_mid_frame();
    logic active;
    clear_hits();
    random_hits(5);
    drive_frame(5, 0, 29, 1'b0);
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL midrst_busy: busy=%0b, want 1", busy);
    else n_pass++;
    aresetn = 1'b0;
    #2;
    n_checks++;
    if ({pos_vld, busy, decode_fail, err_cnt, err_pos} !== '0)
      $display("FAIL midrst_async: vld=%0b busy=%0b fail=%0b cnt=%0d pos=%h, want all 0",
               pos_vld, busy, decode_fail, err_cnt, err_pos);
    else n_pass++;
    tick();
    aresetn = 1'b1;
    active = 1'b0;
    for (int c = 0; c < 70; c++) begin
      eval_vld  = 1'b1;
      start     = 1'b0;
      alpha_idx = 32'($urandom);
      root_hit  = 4'($urandom);
      tick();
      if (busy || pos_vld) active = 1'b1;
    end
    idle_inputs();
    n_checks++;
    if (active !== 1'b0)
      $display("FAIL nostart_ignored: activity=%0b, want 0", active);
    else n_pass++;
    clear_hits();
    random_hits(4);
    model(4);
    drive_frame(4, 0, CN - 1, 1'b1);
    n_checks++;
    if (pos_vld !== 1'b1 || {err_cnt, decode_fail, err_pos} !== {exp_cnt, exp_fail, exp_pos})
      $display("FAIL postrst_model: vld=%0b cnt=%0d fail=%0b pos=%h, want 1 %0d %0b %h",
               pos_vld, err_cnt, decode_fail, err_pos, exp_cnt, exp_fail, exp_pos);
    else n_pass++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_no_errors();
    test_two_errors();
    test_same_beat();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
